// File: rtl/mem_io_if.sv
// Bundle of MEM-stage inputs, UART handshakes, event counter enables and WB-stage
// results exchanged between the pipeline and mem_io_unit.
`timescale 1ns/1ps
interface mem_io_if #(
  parameter int unsigned NUM_CNT = 2
);
  logic               valid_mem;
  logic [31:0]        inst_mem;
  logic [31:0]        alu_mem;
  logic [31:0]        store_data;
  logic [NUM_CNT-1:0] cnt_evt;
  logic [7:0]         uart_rx_data;
  logic               uart_rx_valid;
  logic               uart_rx_ready;
  logic               uart_tx_ready;
  logic               uart_tx_valid;
  logic [7:0]         uart_tx_data;
  logic               stall;
  logic [3:0]         wb_ld_mask;
  logic               wb_ld_sign;
  logic [1:0]         wb_sel;
  logic               wb_reg_wen;
  logic [1:0]         wb_io_sel;
  logic [31:0]        wb_io_rdata;
  logic               wb_misaligned;

  // The unit itself.
  modport slave (
    input  valid_mem, inst_mem, alu_mem, store_data, cnt_evt,
    input  uart_rx_data, uart_rx_valid, uart_tx_ready,
    output uart_rx_ready, uart_tx_valid, uart_tx_data, stall,
    output wb_ld_mask, wb_ld_sign, wb_sel, wb_reg_wen, wb_io_sel, wb_io_rdata, wb_misaligned
  );

  // The pipeline / UART / event sources driving the unit.
  modport master (
    output valid_mem, inst_mem, alu_mem, store_data, cnt_evt,
    output uart_rx_data, uart_rx_valid, uart_tx_ready,
    input  uart_rx_ready, uart_tx_valid, uart_tx_data, stall,
    input  wb_ld_mask, wb_ld_sign, wb_sel, wb_reg_wen, wb_io_sel, wb_io_rdata, wb_misaligned
  );
endinterface

// File: rtl/mem_io_unit.sv
// MEM-stage load/store decode, misalignment detection, and a small memory-mapped
// IO window (UART status/RX/TX, event counters, counter clear). Produces the
// registered WB-stage control and IO read data one cycle after acceptance.
`timescale 1ns/1ps
module mem_io_unit #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned NUM_CNT   = 2,
  parameter logic [31:0] MMIO_BASE = 32'h8000_0000
) (
  input logic     clk,
  input logic     rst_n,
  mem_io_if.slave bus
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  // Offsets inside the 64-byte IO window (MMIO_BASE is assumed 64-byte aligned).
  localparam logic [5:0] OFF_STATUS = 6'h00;
  localparam logic [5:0] OFF_RX     = 6'h04;
  localparam logic [5:0] OFF_TX     = 6'h08;
  localparam logic [5:0] OFF_CNT0   = 6'h10;
  localparam logic [5:0] OFF_CLR    = 6'h20;

  typedef enum logic [1:0] {
    WB_PC4  = 2'd0,
    WB_DATA = 2'd1,
    WB_ALU  = 2'd2
  } wb_sel_e;

  typedef enum logic [1:0] {
    IO_MEM    = 2'd0,
    IO_STATUS = 2'd1,
    IO_RX     = 2'd2,
    IO_CNT    = 2'd3
  } io_sel_e;

  typedef enum logic {
    TX_IDLE = 1'b0,
    TX_BUSY = 1'b1
  } tx_state_e;

  typedef struct packed {
    logic [3:0] ld_mask;
    logic       ld_sign;
    wb_sel_e    sel;
    logic       reg_wen;
    io_sel_e    io_sel;
    logic [31:0] io_rdata;
    logic       misaligned;
  } wb_t;

  tx_state_e        r_state;
  tx_state_e        w_state_nxt;
  logic [7:0]       r_tx_data;
  logic [CNT_W-1:0] r_cnt [NUM_CNT];
  wb_t              r_wb;
  wb_t              w_wb_nxt;

  logic [6:0] w_opcode;
  logic [2:0] w_funct3;
  logic       w_is_load, w_is_store, w_is_branch, w_is_jump;
  logic       w_misaligned;
  logic       w_io_hit;
  logic [5:0] w_io_off;
  logic       w_io_store;
  logic       w_tx_store;
  logic       w_io_load;
  logic       w_stall;
  logic       w_accept;
  logic       w_tx_fire;
  logic       w_clr;
  logic       w_rx_pop;

  // Instruction decode and IO address match.
  assign w_opcode    = bus.inst_mem[6:0];
  assign w_funct3    = bus.inst_mem[14:12];
  assign w_is_load   = (w_opcode == OP_LOAD);
  assign w_is_store  = (w_opcode == OP_STORE);
  assign w_is_branch = (w_opcode == OP_BRANCH);
  assign w_is_jump   = (w_opcode == OP_JAL) || (w_opcode == OP_JALR);

  // funct3[1:0]: 00 byte, 01 halfword, 10 word (same for loads and stores).
  assign w_misaligned = (w_is_load || w_is_store) &&
                        (((w_funct3[1:0] == 2'b01) && bus.alu_mem[0]) ||
                         ((w_funct3[1:0] == 2'b10) && (bus.alu_mem[1:0] != 2'b00)));

  assign w_io_hit   = (bus.alu_mem[31:6] == MMIO_BASE[31:6]);
  assign w_io_off   = bus.alu_mem[5:0];
  assign w_io_store = w_is_store && w_io_hit && !w_misaligned;
  assign w_tx_store = w_io_store && (w_io_off == OFF_TX);
  assign w_io_load  = w_is_load && (w_funct3 == 3'b010) && w_io_hit && !w_misaligned;

  // A TX store must wait for the transmitter to drain the previous byte.
  assign w_stall   = bus.valid_mem && w_tx_store && (r_state == TX_BUSY);
  assign w_accept  = bus.valid_mem && !w_stall;
  assign w_tx_fire = w_accept && w_tx_store;
  assign w_clr     = w_accept && w_io_store && (w_io_off == OFF_CLR);
  assign w_rx_pop  = w_accept && w_io_load && (w_io_off == OFF_RX) && bus.uart_rx_valid;

  // TX FSM next state.
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and infers a latch.
    w_state_nxt = r_state;
    unique case (r_state)
      TX_IDLE: if (w_tx_fire)          w_state_nxt = TX_BUSY;
      TX_BUSY: if (bus.uart_tx_ready)  w_state_nxt = TX_IDLE;
      default:                         w_state_nxt = TX_IDLE;
    endcase
  end

  // TX FSM state register; reset drops uart_tx_valid without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every register samples pre-edge values.
    if (!rst_n) r_state <= TX_IDLE;
    else        r_state <= w_state_nxt;
  end

  // TX byte holding register, loaded only when a TX store is accepted in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         r_tx_data <= '0;
    else if (w_tx_fire) r_tx_data <= bus.store_data[7:0];
  end

  // Event counters: clear store has priority over a same-cycle increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the counter array is reset element by element; being an array does not exempt it from reset.
      for (int k = 0; k < NUM_CNT; k++) r_cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CNT; k++) begin
        if (w_clr)                r_cnt[k] <= '0;
        else if (bus.cnt_evt[k])  r_cnt[k] <= r_cnt[k] + CNT_W'(1);
      end
    end
  end

  // WB-stage values for the instruction accepted this cycle; bubbles stay all-zero.
  always_comb begin
    w_wb_nxt = '0;
    if (w_accept) begin
      w_wb_nxt.misaligned = w_misaligned;
      if (w_is_jump)      w_wb_nxt.sel = WB_PC4;
      else if (w_is_load) w_wb_nxt.sel = WB_DATA;
      else                w_wb_nxt.sel = WB_ALU;
      w_wb_nxt.reg_wen = !(w_is_store || w_is_branch || w_misaligned);

      if (w_is_load && !w_misaligned) begin
        unique case (w_funct3[1:0])
          2'b00:   w_wb_nxt.ld_mask = 4'b0001 << bus.alu_mem[1:0];
          2'b01:   w_wb_nxt.ld_mask = 4'b0011 << bus.alu_mem[1:0];
          default: w_wb_nxt.ld_mask = 4'b1111;
        endcase
        w_wb_nxt.ld_sign = !w_funct3[2];
      end

      // IO reads are word-only; unmapped offsets leave io_sel=memory and data=0.
      if (w_io_load) begin
        if (w_io_off == OFF_STATUS) begin
          w_wb_nxt.io_sel   = IO_STATUS;
          w_wb_nxt.io_rdata = {30'd0, bus.uart_rx_valid, (r_state == TX_IDLE)};
        end else if (w_io_off == OFF_RX) begin
          w_wb_nxt.io_sel   = IO_RX;
          w_wb_nxt.io_rdata = bus.uart_rx_valid ? {24'd0, bus.uart_rx_data} : 32'd0;
        end else begin
          for (int k = 0; k < NUM_CNT; k++) begin
            if (w_io_off == OFF_CNT0 + 6'(4 * k)) begin
              w_wb_nxt.io_sel   = IO_CNT;
              w_wb_nxt.io_rdata = 32'(r_cnt[k]);
            end
          end
        end
      end
    end
  end

  // MEM -> WB pipeline register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_wb <= '0;
    else        r_wb <= w_wb_nxt;
  end

  assign bus.stall         = w_stall;
  assign bus.uart_rx_ready = w_rx_pop;
  assign bus.uart_tx_valid = (r_state == TX_BUSY);
  assign bus.uart_tx_data  = r_tx_data;
  assign bus.wb_ld_mask    = r_wb.ld_mask;
  assign bus.wb_ld_sign    = r_wb.ld_sign;
  assign bus.wb_sel        = r_wb.sel;
  assign bus.wb_reg_wen    = r_wb.reg_wen;
  assign bus.wb_io_sel     = r_wb.io_sel;
  assign bus.wb_io_rdata   = r_wb.io_rdata;
  assign bus.wb_misaligned = r_wb.misaligned;

endmodule

// File: doc/mem_io_unit.md
MEM_IO_UNIT -- requirements
Module: mem_io_unit

Interface
REQ-001 The block SHALL have parameter CNT_W, default 32: counter width, 1..64.
REQ-002 The block SHALL have parameter NUM_CNT, default 2: number of event counters, 1..4.
REQ-003 The block SHALL have parameter MMIO_BASE, default 32'h8000_0000: base address of the IO window.
REQ-004 clk  in  1  single clock; all state on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 valid_mem  in  1  MEM-stage instruction is real (0 = bubble).
REQ-007 inst_mem  in  32  MEM-stage instruction.
REQ-008 alu_mem  in  32  MEM-stage effective address.
REQ-009 store_data  in  32  MEM-stage rs2 value.
REQ-010 cnt_evt  in  NUM_CNT  per-counter increment enables.
REQ-011 uart_rx_data  in  8  received byte.
REQ-012 uart_rx_valid  in  1  RX byte available.
REQ-013 uart_rx_ready  out  1  RX byte consumed this cycle.
REQ-014 uart_tx_ready  in  1  transmitter accepts a byte.
REQ-015 uart_tx_valid  out  1  TX byte offered.
REQ-016 uart_tx_data  out  8  TX byte.
REQ-017 stall  out  1  hold the MEM instruction this cycle.
REQ-018 wb_ld_mask  out  4  byte-lane mask, WB stage.
REQ-019 wb_ld_sign  out  1  sign-extend load, WB stage.
REQ-020 wb_sel  out  2  writeback source (PC+4 / data out / ALU out), WB stage.
REQ-021 wb_reg_wen  out  1  register write enable, WB stage.
REQ-022 wb_io_sel  out  2  0 memory, 1 UART status, 2 UART RX data, 3 counter.
REQ-023 wb_io_rdata  out  32  IO read data, WB stage.
REQ-024 wb_misaligned  out  1  MEM instruction was a misaligned load or store.

Function
REQ-025 IO map (offset from MMIO_BASE): 0x00 UART status {rx_valid, tx_idle} in bits [1:0]; 0x04 RX data; 0x08 TX data (store only); 0x10+4k counter k, k < NUM_CNT; 0x20 counter clear (store only).
REQ-026 The MEM instruction is accepted on a cycle with valid_mem=1 and stall=0; only accepted instructions cause side effects or a nonzero wb_reg_wen.
REQ-027 All wb_* outputs SHALL be registered, giving 1-cycle latency MEM to WB; a non-accepted cycle loads a bubble: all wb_* outputs 0.
REQ-028 Load lanes: LB/LBU give 1<<addr[1:0]; LH/LHU give 3<<addr[1:0]; LW gives 4'b1111. wb_ld_sign is 0 only for LBU and LHU.
REQ-029 Misaligned access: halfword with addr[0]=1, or word with addr[1:0]!=0. Result: wb_misaligned=1, wb_ld_mask=0, wb_reg_wen=0, no IO side effect.
REQ-030 wb_sel: PC+4 for JAL/JALR, data out for LOAD, ALU out otherwise. wb_reg_wen=0 for STORE and BRANCH.
REQ-031 IO loads are word-only: wb_io_rdata is zero-extended; counters are truncated to the low 32 bits; an unmapped IO offset returns 0 with wb_io_sel=0.
REQ-032 An accepted RX-data load pulses uart_rx_ready for exactly that cycle and returns {24'b0, uart_rx_data}; with uart_rx_valid=0 it returns 0 and there is no pulse.
REQ-033 TX FSM, IDLE: an accepted TX store latches store_data[7:0] and moves to BUSY next cycle.
REQ-034 TX FSM, BUSY: uart_tx_valid=1 and uart_tx_data held stable; uart_tx_valid=1 and uart_tx_ready=1 returns the FSM to IDLE.
REQ-035 A TX store that arrives while BUSY asserts stall combinationally until the handshake cycle; it is accepted on the cycle the FSM is IDLE.
REQ-036 Counter k increments by 1 when cnt_evt[k]=1 and wraps from all-ones to 0.
REQ-037 An accepted store to 0x20 zeroes all counters on the next edge; the clear wins over a same-cycle increment.

Reset
REQ-038 While rst_n=0: counters=0, FSM=IDLE, uart_tx_valid=0, uart_tx_data=0, all wb_* outputs=0; asserting reset mid-handshake drops uart_tx_valid immediately.

Verification
REQ-039 LH at addr 0x102, valid -> next cycle wb_ld_mask=4'b1100, wb_ld_sign=1, wb_sel=data out, wb_reg_wen=1.
REQ-040 LW at 0x101 -> wb_misaligned=1, wb_ld_mask=0, wb_reg_wen=0; SW at 0x106 -> wb_misaligned=1 and no TX.
REQ-041 Two back-to-back stores of 0x41 and 0x42 to 0x08, uart_tx_ready=0 for 3 cycles -> stall=1 for those cycles; bytes 0x41 then 0x42 are handshaken in order.
REQ-042 CNT_W=4, cnt_evt[0]=1 for 17 cycles from reset -> counter 0 reads 1; a clear store coinciding with an increment -> counter reads 0.
REQ-043 LW at 0x04 with uart_rx_valid=1, data 0x5A -> uart_rx_ready pulses once, wb_io_rdata=0x5A, wb_io_sel=2; with uart_rx_valid=0 -> wb_io_rdata=0 and no pulse.
REQ-044 rst_n pulled low mid-BUSY, asynchronously to clk -> uart_tx_valid=0 and all wb_* outputs=0 before the next edge.
